// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and helpers
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_e;

  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - bit-period counter with mid-bit and end-of-bit ticks
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CW           = $clog2(CLKS_PER_BIT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  output logic half_tick_o,
  output logic full_tick_o
);

  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Restarts at the bit boundary so the count never exceeds one bit period.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || cnt_q == FULL_CNT) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign half_tick_o = (cnt_q == HALF_CNT);
  assign full_tick_o = (cnt_q == FULL_CNT);

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - parametrised UART receiver with valid/ready output
// Mid-bit sampling, glitch rejection on the start bit, parity/framing/overrun flags.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ  = 50000000,
  parameter int BAUD_RATE   = 115200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam parity_e PAR_MODE = (PARITY == 1) ? PAR_EVEN :
                                 (PARITY == 2) ? PAR_ODD  : PAR_NONE;

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_core: DATA_BITS must be within 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_rx_core: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 8) begin : g_bad_clks_per_bit
    $error("uart_rx_core: CLKS_PER_BIT must be at least 8");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("uart_rx_core: SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_prev_q;
  logic                   rx_s;
  logic                   fall;

  rx_state_e              state_q, state_d;
  logic [IW-1:0]          bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   done_q, done_d;

  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   rx_perr_q, rx_perr_d;
  logic                   rx_ferr_q, rx_ferr_d;
  logic                   overrun_q, overrun_d;

  logic                   tmr_clear;
  logic                   half_tick;
  logic                   full_tick;
  logic                   exp_par;
  logic                   accept;

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign fall    = rx_prev_q & ~rx_s;
  assign exp_par = (^shift_q) ^ (PAR_MODE == PAR_ODD);
  assign accept  = rx_valid_q & rx_ready;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (tmr_clear),
    .half_tick_o(half_tick),
    .full_tick_o(full_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], uart_rx};
      rx_prev_q <= rx_s;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    done_d    = 1'b0;
    tmr_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tmr_clear = 1'b1;
        if (fall) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (half_tick) begin
          tmr_clear = 1'b1;
          if (rx_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DATA;
            bit_idx_d = '0;
            perr_d    = 1'b0;
            ferr_d    = 1'b0;
          end
        end
      end
      ST_DATA: begin
        // Right shift puts the first (LSB) bit at position 0 after DATA_BITS samples.
        if (full_tick) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == IW'(DATA_BITS - 1)) begin
            bit_idx_d = '0;
            state_d   = (PAR_MODE == PAR_NONE) ? ST_STOP : ST_PARITY;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (full_tick) begin
          perr_d  = (rx_s != exp_par);
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (full_tick) begin
          if (!rx_s) begin
            ferr_d = 1'b1;
          end
          if (bit_idx_q == IW'(STOP_BITS - 1)) begin
            done_d    = 1'b1;
            bit_idx_d = '0;
            state_d   = rx_s ? ST_IDLE : ST_WAIT_HIGH;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      ST_WAIT_HIGH: begin
        tmr_clear = 1'b1;
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        tmr_clear = 1'b1;
      end
    endcase
  end

  // A completing frame may load in the same cycle the held word is accepted.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    overrun_d  = overrun_q;
    if (accept) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end
    if (done_q) begin
      if (!rx_valid_q || accept) begin
        rx_data_d  = shift_q;
        rx_perr_d  = perr_q;
        rx_ferr_d  = ferr_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      done_q     <= done_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = rx_perr_q;
  assign frame_err  = rx_ferr_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - scoreboard bench for uart_rx_core
module tb_uart_rx_core;

  localparam int CPB = 434;

  typedef logic [10:0] exp_t;  // {data[8:0], parity_err, frame_err}

  logic clk;
  logic rst_n;
  logic rx0, rx1, rx2;
  logic rdy0, rdy1, rdy2;
  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic v0, v1, v2;
  logic pe0, pe1, pe2;
  logic fe0, fe1, fe2;
  logic ov0, ov1, ov2;
  logic b0, b1, b2;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int checks = 0;
  int passes = 0;

  uart_rx_core dut0 (
    .clk(clk), .rst_n(rst_n), .uart_rx(rx0), .rx_data(d0), .rx_valid(v0), .rx_ready(rdy0),
    .parity_err(pe0), .frame_err(fe0), .overrun(ov0), .busy(b0)
  );

  uart_rx_core #(.PARITY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .uart_rx(rx1), .rx_data(d1), .rx_valid(v1), .rx_ready(rdy1),
    .parity_err(pe1), .frame_err(fe1), .overrun(ov1), .busy(b1)
  );

  uart_rx_core #(.DATA_BITS(7), .STOP_BITS(2), .PARITY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .uart_rx(rx2), .rx_data(d2), .rx_valid(v2), .rx_ready(rdy2),
    .parity_err(pe2), .frame_err(fe2), .overrun(ov2), .busy(b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic spurious(input string name, input logic [31:0] act);
    checks++;
    $display("FAIL %s: word 0x%0h delivered, expected none", name, act);
  endtask

  always @(negedge clk) begin
    if (rst_n && v0 && rdy0) begin
      if (q0.size() == 0) spurious("dut0_word", 32'({d0, pe0, fe0}));
      else check("dut0_word", 32'({d0, pe0, fe0}), 32'(q0.pop_front()));
    end
    if (rst_n && v1 && rdy1) begin
      if (q1.size() == 0) spurious("dut1_word", 32'({d1, pe1, fe1}));
      else check("dut1_word", 32'({d1, pe1, fe1}), 32'(q1.pop_front()));
    end
    if (rst_n && v2 && rdy2) begin
      if (q2.size() == 0) spurious("dut2_word", 32'({d2, pe2, fe2}));
      else check("dut2_word", 32'({d2, pe2, fe2}), 32'(q2.pop_front()));
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic v);
    case (d)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  // par < 0 means no parity bit on the line.
  task automatic send(input int d, input logic [8:0] data, input int nbits, input int par,
                      input int nstop, input logic stop_v);
    drive(d, 1'b0);
    wait_clks(CPB);
    for (int i = 0; i < nbits; i++) begin
      drive(d, data[i]);
      wait_clks(CPB);
    end
    if (par >= 0) begin
      drive(d, par[0]);
      wait_clks(CPB);
    end
    for (int i = 0; i < nstop; i++) begin
      drive(d, stop_v);
      wait_clks(CPB);
    end
    drive(d, 1'b1);
    wait_clks(2 * CPB);
  endtask

  initial begin
    rst_n = 1'b0;
    rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
    rdy0 = 1'b1; rdy1 = 1'b1; rdy2 = 1'b1;
    wait_clks(3);
    check("rst_valid", 32'(v0), 0);
    check("rst_busy", 32'(b0), 0);
    check("rst_data", 32'(d0), 0);
    check("rst_overrun", 32'(ov0), 0);
    check("rst_perr", 32'(pe0), 0);
    check("rst_ferr", 32'(fe0), 0);
    rst_n = 1'b1;
    wait_clks(5);

    q0.push_back({9'h0A5, 1'b0, 1'b0});
    send(0, 9'h0A5, 8, -1, 1, 1'b1);
    check("t1_overrun", 32'(ov0), 0);

    q1.push_back({9'h03C, 1'b1, 1'b0});
    send(1, 9'h03C, 8, 1, 1, 1'b1);
    q1.push_back({9'h03C, 1'b0, 1'b0});
    send(1, 9'h03C, 8, 0, 1, 1'b1);

    q2.push_back({9'h041, 1'b0, 1'b0});
    send(2, 9'h041, 7, 1, 2, 1'b1);

    drive(0, 1'b0);
    wait_clks(50);
    check("t3_busy_glitch", 32'(b0), 1);
    wait_clks(50);
    drive(0, 1'b1);
    wait_clks(217);
    check("t3_busy_idle", 32'(b0), 0);

    q0.push_back({9'h055, 1'b0, 1'b1});
    send(0, 9'h055, 8, -1, 1, 1'b0);
    q0.push_back({9'h000, 1'b0, 1'b1});
    drive(0, 1'b0);
    wait_clks(30 * CPB);
    check("t4_busy_break", 32'(b0), 1);
    drive(0, 1'b1);
    wait_clks(20);
    check("t4_busy_after", 32'(b0), 0);
    q0.push_back({9'h012, 1'b0, 1'b0});
    send(0, 9'h012, 8, -1, 1, 1'b1);

    rdy0 = 1'b0;
    q0.push_back({9'h011, 1'b0, 1'b0});
    send(0, 9'h011, 8, -1, 1, 1'b1);
    send(0, 9'h022, 8, -1, 1, 1'b1);
    check("t5_valid_held", 32'(v0), 1);
    check("t5_data_held", 32'(d0), 32'h11);
    check("t5_overrun", 32'(ov0), 1);
    rdy0 = 1'b1;
    wait_clks(2);
    check("t5_valid_clr", 32'(v0), 0);
    check("t5_overrun_clr", 32'(ov0), 0);

    rdy0 = 1'b0;
    send(0, 9'h033, 8, -1, 1, 1'b1);
    check("t6_valid_pre", 32'(v0), 1);
    drive(0, 1'b0);
    wait_clks(CPB);
    drive(0, 1'b1);
    wait_clks(3 * CPB);
    check("t6_busy_mid", 32'(b0), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_busy", 32'(b0), 0);
    check("t6_rst_valid", 32'(v0), 0);
    check("t6_rst_data", 32'(d0), 0);
    wait_clks(3);
    rst_n = 1'b1;
    rdy0 = 1'b1;
    wait_clks(10);
    q0.push_back({9'h07E, 1'b0, 1'b0});
    send(0, 9'h07E, 8, -1, 1, 1'b1);

    check("sb0_drained", 32'(q0.size()), 0);
    check("sb1_drained", 32'(q1.size()), 0);
    check("sb2_drained", 32'(q2.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
